// File: rtl/ex_muldiv_ctrl_pkg.sv
// ex_muldiv_ctrl_pkg: shared op/state encodings and iteration count for the EX multi-cycle unit.
//   opE    : MUL (low 32 bits), DIVU, REMU, RSVD (reserved, yields 0)
//   stateE : IDLE, BUSY, DONE controller states
//   ITER   : iterations per operation; LAST is the final counter value
package ex_muldiv_ctrl_pkg;
    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10,
        OP_RSVD = 2'b11
    } opE;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } stateE;

    localparam int ITER = 32;
    localparam logic [5:0] LAST = 6'(ITER - 1);
endpackage

// File: rtl/ex_muldiv_ctrl_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring divide.
//   op      : selects MUL (shift-add) or DIVU/REMU (compare/subtract/shift)
//   acc     : 64-bit working register; MUL {partial, multiplier}, DIV {remainder, quotient}
//   b       : multiplicand / divisor
//   accNext : working register after this iteration
module muldiv_step
    import ex_muldiv_ctrl_pkg::*;
(
    input  opE          op,
    input  logic [63:0] acc,
    input  logic [31:0] b,
    output logic [63:0] accNext
);
    logic [32:0] sum;
    logic [32:0] trial;
    logic [32:0] diff;

    // The remainder can reach 2^32-1 before shifting, so the trial value needs 33 bits.
    // A zero divisor always "fits": quotient fills with ones and the remainder ends as a.
    always_comb begin
        sum     = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? b : 32'd0)};
        trial   = acc[63:31];
        diff    = trial - {1'b0, b};
        accNext = (op == OP_MUL)         ? {sum, acc[31:1]} :
                  (trial >= {1'b0, b})   ? {diff[31:0], acc[30:0], 1'b1} :
                                           {trial[31:0], acc[30:0], 1'b0};
    end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage iterative MUL/DIVU/REMU controller with pipeline stall.
//   clk, rst      : clock, asynchronous active-low reset
//   start, op     : multi-cycle op request (held while in EX) and operation select
//   a, b          : forwarded operands, captured on acceptance
//   flush         : EX flush; aborts a running op, blocks acceptance
//   stall         : stall request for fetch/decode/execute registers
//   busy, done    : BUSY-state flag, one-cycle result-valid strobe
//   result        : operation result, zero whenever done is low
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    stateE       state;
    stateE       stateNext;
    logic [5:0]  cnt;
    opE          opReg;
    logic [31:0] bReg;
    logic [63:0] acc;
    logic [63:0] accNext;
    logic        accept;

    muldiv_step uStep (
        .op      (opReg),
        .acc     (acc),
        .b       (bReg),
        .accNext (accNext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 6'd0;
            opReg <= OP_MUL;
            bReg  <= 32'd0;
            acc   <= 64'd0;
        end else begin
            state <= stateNext;
            if (accept) begin
                opReg <= opE'(op);
                bReg  <= b;
                acc   <= {32'd0, a};
                cnt   <= 6'd0;
            end else if (state == S_BUSY) begin
                acc <= accNext;
                cnt <= cnt + 6'd1;
            end
        end
    end

    // Flush wins over completion in BUSY; DONE always returns to IDLE so a start
    // still held by the leaving instruction is never re-accepted.
    always_comb begin
        accept    = (state == S_IDLE) && start && !flush;
        stateNext = (state == S_IDLE) ? (accept ? S_BUSY : S_IDLE) :
                    (state == S_BUSY) ? (flush ? S_IDLE :
                                         (cnt == LAST || opReg == OP_RSVD) ? S_DONE : S_BUSY) :
                                        S_IDLE;
    end

    // stall is gated by rst so it reads 0 during reset even with start asserted.
    always_comb begin
        busy   = (state == S_BUSY);
        done   = (state == S_DONE);
        stall  = rst && (accept || busy);
        result = !done               ? 32'd0 :
                 (opReg == OP_RSVD)  ? 32'd0 :
                 (opReg == OP_REMU)  ? acc[63:32] :
                                       acc[31:0];
    end
endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, EX-stage multi-cycle op request; held high while the op is in EX.
REQ-004 SHALL have port op, input, 2, operation: 00 MUL (low 32 bits), 01 DIVU, 10 REMU, 11 reserved.
REQ-005 SHALL have ports a and b, input, 32 each, forwarded operands (SrcAE / SrcBE2 values).
REQ-006 SHALL have port flush, input, 1, EX flush from hazard logic.
REQ-007 SHALL have port stall, output, 1, stall request to fetch/decode/execute registers.
REQ-008 SHALL have port busy, output, 1, high in BUSY state.
REQ-009 SHALL have port done, output, 1, one-cycle result-valid strobe.
REQ-010 SHALL have port result, output, 32, operation result; valid only while done=1.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 IDLE: start=1 and flush=0 SHALL latch op, a, b, clear 6-bit counter, go to BUSY.
REQ-013 IDLE with flush=1 SHALL ignore start and stay IDLE.
REQ-014 stall SHALL equal (IDLE & start & ~flush) | BUSY, combinationally; 0 in DONE.
REQ-015 BUSY SHALL perform one iteration per cycle: MUL shift-add, DIVU/REMU restoring shift-subtract, 32 iterations, counter 0..31.
REQ-016 BUSY with counter=31 and flush=0 SHALL go to DONE.
REQ-017 op=11 SHALL skip iterations: BUSY for one cycle, then DONE with result 0x00000000.
REQ-018 DONE SHALL assert done=1, drive result, return to IDLE next edge unconditionally.
REQ-019 start asserted in DONE SHALL be ignored (same instruction leaving EX).
REQ-020 flush=1 in BUSY SHALL abort to IDLE next edge; no done; stall low from that edge.
REQ-021 flush=1 in DONE SHALL not suppress done (instruction already completing).
REQ-022 Latency: start sampled at edge N -> done=1 in cycle after edge N+32; 34 cycles of start to IDLE.
REQ-023 MUL SHALL return low 32 bits of unsigned 64-bit product.
REQ-024 DIVU by 0 SHALL return 0xFFFFFFFF; REMU by 0 SHALL return a (RISC-V semantics).
REQ-025 Operand/op changes on inputs after acceptance SHALL not affect the operation.
REQ-026 result SHALL read 0x00000000 whenever done=0.

Reset
REQ-027 rst=0 SHALL force IDLE, counter 0, internal registers 0, asynchronously.
REQ-028 While rst=0 outputs stall, busy, done SHALL be 0 and result 0x00000000.
REQ-029 rst asserted mid-operation SHALL discard the operation; no done after release.

Structure
REQ-030 Shared package SHALL hold op encodings (MUL, DIVU, REMU, RSVD), state encoding, ITER=32.
REQ-031 One combinational sub-module muldiv_step SHALL compute a single iteration (add/shift or compare/subtract/shift); controller instantiates it once.
REQ-032 No other instantiated state; partial product/remainder registers 64 bits in controller.

Verification
REQ-033 MUL a=7 b=6 -> stall 33 cycles incl. acceptance cycle, done one cycle, result 0x0000002A.
REQ-034 MUL a=0xFFFFFFFF b=0xFFFFFFFF -> result 0x00000001; DIVU a=100 b=7 -> 0x0000000E; REMU a=100 b=7 -> 0x00000002.
REQ-035 DIVU a=0x12345678 b=0 -> 0xFFFFFFFF; REMU same operands -> 0x12345678.
REQ-036 flush at BUSY counter=10 -> IDLE next cycle, stall=0, done never asserted; new start then completes normally.
REQ-037 start held through DONE -> exactly one done; start+flush in IDLE -> stall=0, not accepted.
REQ-038 rst pulsed low at counter=20 -> all outputs 0 immediately, IDLE after release, no done.
